// File: rtl/matvec_pkg.sv
// matvec shared types and arithmetic helpers.
// Imported by the interface users, the lanes and the top.
package matvec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  localparam int MAXW = 64;

  // Add two values that are each sign-extended from w bits.
  // The result is the w-bit sum, clamped or wrapped, sign-extended.
  function automatic logic signed [MAXW-1:0] sat_add(
    input logic signed [MAXW-1:0] a,
    input logic signed [MAXW-1:0] b,
    input int                     w,
    input logic                   sat
  );
    logic signed [MAXW-1:0] one;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] t;
    one = MAXW'(1);
    hi  = (one <<< (w - 1)) - one;
    t   = (a + b) <<< (MAXW - w);
    if (sat && (a[MAXW-1] == b[MAXW-1]) &&
        (t[MAXW-1] != a[MAXW-1])) begin
      return a[MAXW-1] ? ~hi : hi;
    end
    return t >>> (MAXW - w);
  endfunction

endpackage

// File: rtl/matvec_if.sv
// matvec streaming bundle: element input stream and result stream.
// Master drives elements and accepts results; slave is the block.
interface matvec_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 28
);
  logic             input_valid;
  logic             input_ready;
  logic [IN_W-1:0]  input_data;
  logic             new_matrix;
  logic             output_valid;
  logic             output_ready;
  logic [OUT_W-1:0] output_data;

  modport master (
    output input_valid,
    output input_data,
    output new_matrix,
    output output_ready,
    input  input_ready,
    input  output_valid,
    input  output_data
  );

  modport slave (
    input  input_valid,
    input  input_data,
    input  new_matrix,
    input  output_ready,
    output input_ready,
    output output_valid,
    output output_data
  );
endinterface

// File: rtl/matvec_param_mac_lane.sv
// One matvec row lane: registered product feeding an accumulator.
// The accumulator saturates or wraps depending on SAT.
module mac_lane
  import matvec_pkg::*;
#(
  parameter int IN_W  = 14,
  parameter int OUT_W = 28,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  w,
  input  logic signed [IN_W-1:0]  x,
  input  logic                    prod_en,
  input  logic                    acc_en,
  input  logic                    clear,
  output logic signed [OUT_W-1:0] acc
);
  localparam int PW = 2 * IN_W;

  logic signed [PW-1:0]    prod_q;
  logic signed [OUT_W-1:0] acc_q;
  logic signed [MAXW-1:0]  sum;

  assign sum = sat_add(MAXW'(acc_q), MAXW'(prod_q),
                       OUT_W, SAT != 0);
  assign acc = acc_q;

  // Full-precision product of the bank word and x element.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
    end else if (prod_en) begin
      prod_q <= PW'(w) * PW'(x);
    end
  end

  // Accumulate products; a clamped value keeps accumulating.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q <= '0;
    end else if (acc_en) begin
      acc_q <= OUT_W'(sum);
    end
  end

endmodule

// File: rtl/matvec_param.sv
// Streaming matrix-vector multiplier with resident W.
// Loads W (optional) and x, runs N lanes, streams y out.
module matvec_param
  import matvec_pkg::*;
#(
  parameter int N     = 8,
  parameter int IN_W  = 14,
  parameter int OUT_W = 28,
  parameter int SAT   = 1
) (
  input logic     clk,
  input logic     reset,
  matvec_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(N * N + 1);
  localparam int JW = $clog2(N + 2);

  localparam logic [LW-1:0] LD_LAST  = LW'(N * N - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [JW-1:0] J_RD     = JW'(N);
  localparam logic [JW-1:0] J_LAST   = JW'(N + 1);

  state_t state_q;
  state_t state_d;

  logic          w_loaded_q;
  logic [LW-1:0] ld_cnt;
  logic [IW-1:0] wr_row;
  logic [IW-1:0] wr_col;
  logic [IW-1:0] x_cnt;
  logic [IW-1:0] o;
  logic [JW-1:0] j;

  logic in_rdy;
  logic w_we;
  logic x_we;
  logic w_done;
  logic x_done;
  logic c_done;
  logic o_load;
  logic o_beat;
  logic o_last;

  logic signed [IN_W-1:0] bank [N][N];
  logic signed [IN_W-1:0] x_r  [N];
  logic signed [IN_W-1:0] rd_w [N];
  logic signed [IN_W-1:0] rd_x;

  logic rd_en;
  logic rd_v;
  logic prod_v;
  logic acc_clr;

  logic signed [OUT_W-1:0] acc [N];

  logic                    ov_q;
  logic signed [OUT_W-1:0] od_q;

  assign bus.input_ready  = in_rdy;
  assign bus.output_valid = ov_q;
  assign bus.output_data  = od_q;

  // Next state and per-cycle strobes for loads and outputs.
  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    w_we    = 1'b0;
    x_we    = 1'b0;
    w_done  = 1'b0;
    x_done  = 1'b0;
    c_done  = 1'b0;
    o_load  = 1'b0;
    o_beat  = 1'b0;
    o_last  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_rdy = 1'b1;
        if (bus.input_valid) begin
          if (bus.new_matrix || !w_loaded_q) begin
            w_we    = 1'b1;
            state_d = S_LOAD_W;
          end else begin
            x_we    = 1'b1;
            state_d = S_LOAD_X;
          end
        end
      end
      S_LOAD_W: begin
        in_rdy = 1'b1;
        if (bus.input_valid) begin
          w_we = 1'b1;
          if (ld_cnt == LD_LAST) begin
            w_done  = 1'b1;
            state_d = S_LOAD_X;
          end
        end
      end
      S_LOAD_X: begin
        in_rdy = 1'b1;
        if (bus.input_valid) begin
          x_we = 1'b1;
          if (x_cnt == IDX_LAST) begin
            x_done  = 1'b1;
            state_d = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        if (j == J_LAST) begin
          c_done  = 1'b1;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (!ov_q) begin
          o_load = 1'b1;
        end else if (bus.output_ready) begin
          o_beat = 1'b1;
          if (o == IDX_LAST) begin
            o_last  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load, compute and output counters plus the W-resident flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt     <= '0;
      wr_row     <= '0;
      wr_col     <= '0;
      x_cnt      <= '0;
      j          <= '0;
      o          <= '0;
      w_loaded_q <= 1'b0;
    end else begin
      if (w_we) begin
        if (w_done) begin
          ld_cnt <= '0;
          wr_row <= '0;
          wr_col <= '0;
        end else begin
          ld_cnt <= ld_cnt + LW'(1);
          if (wr_col == IDX_LAST) begin
            wr_col <= '0;
            wr_row <= wr_row + IW'(1);
          end else begin
            wr_col <= wr_col + IW'(1);
          end
        end
      end
      if (w_done) begin
        w_loaded_q <= 1'b1;
      end
      if (x_we) begin
        x_cnt <= x_done ? '0 : x_cnt + IW'(1);
      end
      if (state_q == S_COMPUTE) begin
        j <= c_done ? '0 : j + JW'(1);
      end
      if (o_beat) begin
        o <= o_last ? '0 : o + IW'(1);
      end
    end
  end

  // Weight banks and x register file; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      bank[wr_row][wr_col] <= bus.input_data;
    end
    if (x_we) begin
      x_r[x_cnt] <= bus.input_data;
    end
  end

  assign rd_en   = (state_q == S_COMPUTE) && (j < J_RD);
  assign acc_clr = (state_q == S_COMPUTE) && (j == '0);

  // Column j read of every bank and of x, one cycle latency.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int r = 0; r < N; r++) begin
        rd_w[r] <= bank[r][j[IW-1:0]];
      end
      rd_x <= x_r[j[IW-1:0]];
    end
  end

  // Valid bits tracking the read and product stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v   <= 1'b0;
      prod_v <= 1'b0;
    end else begin
      rd_v   <= rd_en;
      prod_v <= rd_v;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_lane
    mac_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SAT   (SAT)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .w       (rd_w[r]),
      .x       (rd_x),
      .prod_en (rd_v),
      .acc_en  (prod_v),
      .clear   (acc_clr),
      .acc     (acc[r])
    );
  end

  // Result register: primed with y[0], advanced per output beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q <= 1'b0;
      od_q <= '0;
    end else if (o_load) begin
      ov_q <= 1'b1;
      od_q <= acc[0];
    end else if (o_beat) begin
      if (o_last) begin
        ov_q <= 1'b0;
      end else begin
        od_q <= acc[o + IW'(1)];
      end
    end
  end

endmodule

// File: tb/tb_matvec_param.sv
// Bench for matvec_param: saturating and wrapping instances
// run in lockstep against an arithmetic reference model.
module tb_matvec_param;
  localparam int N     = 8;
  localparam int IN_W  = 14;
  localparam int OUT_W = 28;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  matvec_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  matvec_if #(.IN_W(IN_W), .OUT_W(OUT_W)) busw ();

  assign busw.input_valid  = bus.input_valid;
  assign busw.input_data   = bus.input_data;
  assign busw.new_matrix   = bus.new_matrix;
  assign busw.output_ready = bus.output_ready;

  matvec_param #(
    .N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SAT(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  matvec_param #(
    .N(N), .IN_W(IN_W), .OUT_W(OUT_W), .SAT(0)
  ) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (busw.slave)
  );

  int     n_vec = 0;
  int     n_err = 0;
  int     wm [N][N];
  int     xm [N];
  longint ys [N];
  longint yw [N];
  bit     wl_m = 1'b0;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] sx(
    input logic [OUT_W-1:0] v);
    return 64'(signed'(v));
  endfunction

  function automatic longint fold(input longint v,
                                  input bit sat);
    longint lim;
    longint m;
    lim = longint'(1) << (OUT_W - 1);
    m   = 2 * lim;
    if (sat) begin
      if (v >= lim) return lim - 1;
      if (v < -lim) return -lim;
      return v;
    end
    return (((v + lim) % m) + m) % m - lim;
  endfunction

  task automatic model();
    longint p;
    for (int r = 0; r < N; r++) begin
      ys[r] = 0;
      yw[r] = 0;
      for (int c = 0; c < N; c++) begin
        p = longint'(wm[r][c]) * longint'(xm[c]);
        ys[r] = fold(ys[r] + p, 1'b1);
        yw[r] = fold(yw[r] + p, 1'b0);
      end
    end
  endtask

  function automatic int rnd_el();
    int u;
    u = int'($urandom_range(9));
    if (u == 0) return (1 << (IN_W - 1)) - 1;
    if (u == 1) return -(1 << (IN_W - 1));
    return int'($urandom_range((1 << IN_W) - 1))
           - (1 << (IN_W - 1));
  endfunction

  task automatic fill_w(input int mode, input int v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        wm[r][c] = (mode == 0) ? v :
                   (mode == 1) ? int'(r == c) : rnd_el();
  endtask

  task automatic fill_x(input int mode, input int v);
    for (int i = 0; i < N; i++)
      xm[i] = (mode == 0) ? v :
              (mode == 1) ? i + 1 : rnd_el();
  endtask

  task automatic put(input int d, input bit nm,
                     input int gap);
    int   b;
    logic rdy;
    bit   got;
    b   = 0;
    got = 1'b0;
    while (gap > 0 && int'($urandom_range(99)) < gap) begin
      bus.input_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.input_valid = 1'b1;
    bus.input_data  = IN_W'(d);
    bus.new_matrix  = nm;
    while (!got && b < 500) begin
      rdy = bus.input_ready;
      @(posedge clk); #1;
      if (rdy) got = 1'b1;
      else b++;
    end
    if (!got) chk("beat_timeout", b, 0);
    bus.input_valid = 1'b0;
  endtask

  task automatic collect(input int mode);
    int   o;
    int   cyc;
    bit   stalled;
    bit   ir_bad;
    logic rdy;
    logic [OUT_W-1:0] held;
    o       = 0;
    cyc     = 0;
    stalled = 1'b0;
    ir_bad  = 1'b0;
    held    = '0;
    while (o < N && cyc < 2000) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 3 == 0);
      else                rdy = 1'($urandom_range(1));
      bus.output_ready = rdy;
      if (stalled) begin
        chk("hold_valid", bus.output_valid, 1);
        chk("hold_data", sx(bus.output_data), sx(held));
      end
      if (bus.output_valid) begin
        if (bus.input_ready) ir_bad = 1'b1;
        if (rdy) begin
          chk("y_sat", sx(bus.output_data), ys[o]);
          chk("y_wrap_v", busw.output_valid, 1);
          chk("y_wrap", sx(busw.output_data), yw[o]);
          o++;
          stalled = 1'b0;
        end else begin
          held    = bus.output_data;
          stalled = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.output_ready = 1'b0;
    chk("out_beats", o, N);
    chk("ir_during_out", ir_bad, 0);
    chk("ov_after", bus.output_valid, 0);
    chk("ir_after", bus.input_ready, 1);
  endtask

  task automatic problem(input bit nm, input int gap,
                         input int mode, input bit meas);
    bit ldw;
    int k;
    ldw = nm || !wl_m;
    if (ldw)
      for (int i = 0; i < N * N; i++)
        put(wm[i / N][i % N],
            (i == 0) ? nm : 1'($urandom_range(1)), gap);
    for (int i = 0; i < N; i++)
      put(xm[i],
          (i == 0 && !ldw) ? nm : 1'($urandom_range(1)), gap);
    if (ldw) wl_m = 1'b1;
    chk("ir_after_x", bus.input_ready, 0);
    model();
    if (meas) begin
      k = 0;
      while (!bus.output_valid && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      chk("latency", k, N + 3);
    end
    collect(mode);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.new_matrix   = 1'b0;
    bus.output_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wl_m  = 1'b0;
  endtask

  initial begin
    bit nm;
    do_reset();
    chk("rst_ir", bus.input_ready, 1);
    chk("rst_ov", bus.output_valid, 0);
    chk("rst_od", sx(bus.output_data), 0);
    chk("rst_ov_w", busw.output_valid, 0);

    fill_w(1, 0);
    fill_x(1, 0);
    problem(1'b1, 0, 0, 1'b1);

    fill_w(0, 3);
    fill_x(0, 1);
    problem(1'b1, 0, 0, 1'b0);
    fill_x(0, 2);
    problem(1'b0, 0, 0, 1'b0);

    fill_w(0, 8191);
    fill_x(0, 8191);
    problem(1'b1, 0, 0, 1'b0);
    fill_x(0, -8192);
    problem(1'b0, 0, 0, 1'b0);

    fill_w(2, 0);
    fill_x(2, 0);
    problem(1'b1, 0, 1, 1'b0);

    fill_w(2, 0);
    for (int i = 0; i < 30; i++)
      put(wm[i / N][i % N], i == 0, 0);
    do_reset();
    chk("rst2_ir", bus.input_ready, 1);
    fill_w(2, 0);
    fill_x(2, 0);
    problem(1'b0, 0, 0, 1'b0);

    repeat (100) begin
      nm = (int'($urandom_range(99)) < 30);
      if (nm || !wl_m) fill_w(2, 0);
      fill_x(2, 0);
      problem(nm, 30, 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
